key_event_controller: RTL and testbench

Multi-key debounce scheduler for the board push-button inputs. It owns a single shared sample-tick prescaler and time-multiplexes one stability checker across all keys in round-robin order. It publishes debounced key levels plus a queued stream of press/release events over a valid/ready handshake. Downstream crypto control logic consumes the events instead of reading raw, chattering key pins.

---
 rtl/key_event_controller_if.sv | 12 +
 rtl/key_event_controller.sv | 145 ++++++++++++++
 tb/tb_key_event_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_controller_if.sv
// Key-event stream: head-of-queue event offered by the controller, accepted by the consumer.
interface key_event_controller_if #(
  parameter int KW = 2
);
  logic          ev_valid;
  logic [KW-1:0] ev_key;
  logic          ev_press;
  logic          ev_ready;

  modport master (output ev_valid, ev_key, ev_press, input ev_ready);
  modport slave  (input ev_valid, ev_key, ev_press, output ev_ready);
endinterface

// File: rtl/key_event_controller.sv
// Multi-key debouncer: one shared prescaler and one time-multiplexed stability checker
// scanning all keys, emitting press/release events through a small FWFT queue.
module key_event_controller #(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 65536,
  parameter int STABLE_TICKS = 3,
  parameter int FIFO_DEPTH   = 4,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_KEYS-1:0]      key_in,
  output logic [N_KEYS-1:0]      key_level,
  key_event_controller_if.master ev,
  output logic                   overflow,
  input  logic                   clear_ovf
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = KW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [N_KEYS-1:0] sync1, sync2;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  state_t            state, state_nx;
  logic [KW-1:0]     idx;
  logic [CW-1:0]     cnt [N_KEYS];
  logic [N_KEYS-1:0] visit;
  logic              push, push_press;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              empty, full, pop, accept;
  logic [EW-1:0]     head;
  logic [KW-1:0]     hold_key;
  logic              hold_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt <= '0;
    else      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      // idx parks at 0 while idle, so the first scan visit is always key 0
      idx   <= (state == SCAN) ? idx + KW'(1) : '0;
    end
  end

  always_comb begin
    state_nx   = state;
    visit      = '0;
    push       = 1'b0;
    push_press = 1'b0;
    case (state)
      IDLE:    if (tick) state_nx = SCAN;
      SCAN:    if (idx == KW'(N_KEYS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (state == SCAN && idx == KW'(i)) begin
        visit[i] = 1'b1;
        if (sync2[i] != key_level[i] && cnt[i] == CW'(STABLE_TICKS - 1)) begin
          push       = 1'b1;
          push_press = sync2[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (visit[i]) begin
          if (sync2[i] == key_level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
            key_level[i] <= sync2[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = !empty && ev.ev_ready;
  assign accept = push && (!full || pop);
  assign head   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= {idx, push_press};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      hold_key   <= '0;
      hold_press <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr       <= rptr + (AW+1)'(1);
        hold_key   <= head[EW-1:1];
        hold_press <= head[0];
      end
      if (push && !accept) overflow <= 1'b1;
      else if (clear_ovf)  overflow <= 1'b0;
    end
  end

  // When empty, the output holds the last popped event rather than a stale slot
  always_comb begin
    ev.ev_valid = !empty;
    ev.ev_key   = empty ? hold_key   : head[EW-1:1];
    ev.ev_press = empty ? hold_press : head[0];
  end
endmodule

// File: tb/tb_key_event_controller.sv
// Bench for key_event_controller: vector table, hand sequences and random stimulus,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_key_event_controller;
  localparam int NK = 4;
  localparam int TD = 8;
  localparam int ST = 3;
  localparam int FD = 4;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic          overflow;
  logic          clear_ovf;

  key_event_controller_if #(.KW(KW)) ev();

  key_event_controller #(
    .N_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .ev(ev), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned key;
    bit          press;
  } ev_t;

  typedef struct {
    logic [NK-1:0] key_in;
    bit            ready;
    bit            clr;
    int unsigned   cycles;
    logic [NK-1:0] exp_level;
    bit            exp_ovf;
    int unsigned   exp_npop;
  } vec_t;

  // behavioural model state
  ev_t           mq[$];
  ev_t           m_last;
  logic [NK-1:0] m_level, d1, d2;
  int unsigned   run[NK];
  bit            m_ovf;
  int unsigned   k;

  ev_t           obs[$];
  int unsigned   tests = 0;
  int unsigned   fails = 0;

  task automatic model_reset();
    mq.delete();
    m_last.key   = 0;
    m_last.press = 1'b0;
    m_level = '0;
    d1 = '0;
    d2 = '0;
    for (int i = 0; i < NK; i++) run[i] = 0;
    m_ovf = 1'b0;
    k = 0;
  endtask

  // One clock edge of the model: key (k mod TD) is sampled once per tick period,
  // and a level flips after ST consecutive samples that disagree with it.
  task automatic model_edge();
    bit          do_pop, do_push, ok;
    ev_t         e;
    int unsigned i;
    if (rst) begin
      do_pop  = (mq.size() != 0) && (ev.ev_ready == 1'b1);
      do_push = 1'b0;
      e.key   = 0;
      e.press = 1'b0;
      if (k >= TD && (k % TD) < NK) begin
        i = k % TD;
        if (d2[i] != m_level[i]) begin
          run[i]++;
          if (run[i] == ST) begin
            m_level[i] = d2[i];
            run[i]     = 0;
            do_push    = 1'b1;
            e.key      = i;
            e.press    = d2[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      ok = (mq.size() < FD) || do_pop;
      if (clear_ovf) m_ovf = 1'b0;
      if (do_push && !ok) m_ovf = 1'b1;
      if (do_pop) m_last = mq.pop_front();
      if (do_push && ok) mq.push_back(e);
      d2 = d1;
      d1 = key_in;
      k++;
    end
  endtask

  task automatic check(string name);
    logic [KW-1:0] ek;
    logic          ep, ev_exp;
    ev_exp = (mq.size() != 0);
    if (ev_exp) begin
      ek = KW'(mq[0].key);
      ep = mq[0].press;
    end else begin
      ek = KW'(m_last.key);
      ep = m_last.press;
    end
    tests++;
    if (key_level !== m_level || ev.ev_valid !== ev_exp || overflow !== m_ovf ||
        ev.ev_key !== ek || ev.ev_press !== ep) begin
      fails++;
      $display("FAIL %s t=%0t got level=%h valid=%b key=%0d press=%b ovf=%b, want level=%h valid=%b key=%0d press=%b ovf=%b",
               name, $time, key_level, ev.ev_valid, ev.ev_key, ev.ev_press, overflow,
               m_level, ev_exp, ek, ep, m_ovf);
    end
  endtask

  task automatic expect_eq(string name, int unsigned actual, int unsigned required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, actual, required);
    end
  endtask

  task automatic step(string name);
    ev_t o;
    if (rst && ev.ev_valid === 1'b1 && ev.ev_ready === 1'b1) begin
      o.key   = int'(ev.ev_key);
      o.press = ev.ev_press;
      obs.push_back(o);
    end
    model_edge();
    @(posedge clk);
    #1;
    check(name);
  endtask

  vec_t rows[11];

  initial begin
    int unsigned waited;

    rows[0]  = '{4'hF, 1'b1, 1'b0, 50, 4'hF, 1'b0, 4};
    rows[1]  = '{4'h0, 1'b1, 1'b0, 40, 4'h0, 1'b0, 4};
    rows[2]  = '{4'h4, 1'b1, 1'b0, 40, 4'h4, 1'b0, 1};
    rows[3]  = '{4'h0, 1'b1, 1'b0, 40, 4'h0, 1'b0, 1};
    rows[4]  = '{4'h9, 1'b1, 1'b0, 40, 4'h9, 1'b0, 2};
    rows[5]  = '{4'h0, 1'b1, 1'b0, 40, 4'h0, 1'b0, 2};
    rows[6]  = '{4'hF, 1'b0, 1'b0, 40, 4'hF, 1'b0, 0};
    rows[7]  = '{4'hE, 1'b0, 1'b0, 40, 4'hE, 1'b1, 0};
    rows[8]  = '{4'hE, 1'b1, 1'b0, 10, 4'hE, 1'b1, 4};
    rows[9]  = '{4'hE, 1'b1, 1'b1,  1, 4'hE, 1'b0, 0};
    rows[10] = '{4'h0, 1'b1, 1'b0, 40, 4'h0, 1'b0, 3};

    model_reset();
    rst         = 1'b1;
    key_in      = '1;
    clear_ovf   = 1'b0;
    ev.ev_ready = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_async_start");

    for (int c = 0; c < 20; c++) step("reset_hold");

    rst = 1'b1;
    for (int r = 0; r < 11; r++) begin
      key_in      = rows[r].key_in;
      ev.ev_ready = rows[r].ready;
      clear_ovf   = rows[r].clr;
      obs.delete();
      for (int c = 0; c < int'(rows[r].cycles); c++) step("vec");
      clear_ovf = 1'b0;
      expect_eq("vec_level", int'(key_level), int'(rows[r].exp_level));
      expect_eq("vec_ovf", int'(overflow), int'(rows[r].exp_ovf));
      expect_eq("vec_npop", obs.size(), rows[r].exp_npop);
      if (r == 4 && obs.size() == 2) begin
        expect_eq("simul_first_key", obs[0].key, 0);
        expect_eq("simul_second_key", obs[1].key, 3);
      end
      if (r == 8 && obs.size() == 4) begin
        for (int j = 0; j < 4; j++) begin
          expect_eq("drain_key", obs[j].key, j);
          expect_eq("drain_press", int'(obs[j].press), 1);
        end
      end
    end

    // chatter on key 1: 12-cycle pulses never survive three consecutive samples
    obs.delete();
    ev.ev_ready = 1'b1;
    key_in      = '0;
    for (int t = 0; t < 17; t++) begin
      key_in[1] = ~key_in[1];
      for (int c = 0; c < 12; c++) step("chatter");
      expect_eq("chatter_level1", int'(key_level[1]), 0);
    end
    key_in = '0;
    for (int c = 0; c < 20; c++) step("chatter_tail");
    expect_eq("chatter_npop", obs.size(), 0);

    for (int s = 0; s < 60; s++) begin
      int unsigned hold, mode;
      hold   = $urandom_range(1, 40);
      mode   = $urandom_range(0, 2);
      key_in = NK'($urandom_range(0, 15));
      for (int c = 0; c < int'(hold); c++) begin
        ev.ev_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        clear_ovf   = ($urandom_range(0, 15) == 0);
        step("random");
      end
    end
    clear_ovf = 1'b0;

    // reset during a scan with two events queued
    ev.ev_ready = 1'b1;
    key_in      = '0;
    for (int c = 0; c < 60; c++) step("settle");
    ev.ev_ready = 1'b0;
    key_in      = 4'h3;
    waited      = 0;
    while (mq.size() < 2 && waited < 60) begin
      step("fill_two");
      waited++;
    end
    expect_eq("two_queued_in_time", int'(waited < 60), 1);
    expect_eq("two_queued_valid", int'(ev.ev_valid), 1);
    waited = 0;
    while (!(k >= TD && (k % TD) < NK) && waited < TD) begin
      step("to_scan");
      waited++;
    end
    #2 rst = 1'b0;
    #1;
    expect_eq("async_rst_valid", int'(ev.ev_valid), 0);
    expect_eq("async_rst_level", int'(key_level), 0);
    model_reset();
    check("async_rst_all");
    key_in = '0;
    for (int c = 0; c < 3; c++) step("rst_hold2");
    rst         = 1'b1;
    ev.ev_ready = 1'b1;
    obs.delete();
    for (int c = 0; c < 40; c++) step("post_rst");
    expect_eq("post_rst_npop", obs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
